// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared modes, default widths and DCF timebase divisors for tick_gen_multi
package tick_gen_pkg;
  typedef enum logic {MODE_PERIODIC, MODE_ONESHOT} mode_t;
  localparam int TICK_CNT_W = 26;
  localparam int TICK_DEFAULT_DIV = 10000000;
  localparam int DIV_1S = 10000000;
  localparam int DIV_100MS = 1000000;
  localparam int DIV_10MS = 100000;
  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tick_gen_if.sv
// tick_gen_if: divisor/mode load handshake between a controller and tick_gen_multi
interface tick_gen_if import tick_gen_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = TICK_CNT_W
);
  localparam int CH_W = chan_w(CHANNELS);
  logic load_valid;
  logic load_ready;
  logic [CH_W-1:0] load_chan;
  logic [CNT_W-1:0] load_div;
  mode_t load_mode;
  modport master(output load_valid, load_chan, load_div, load_mode, input load_ready);
  modport slave(input load_valid, load_chan, load_div, load_mode, output load_ready);
endinterface

// File: rtl/tick_gen_chan.sv
// tick_gen_chan: one divider channel with loadable divisor, periodic/one-shot mode and pause
module tick_gen_chan import tick_gen_pkg::*; #(
  parameter int CNT_W = TICK_CNT_W,
  parameter int DEFAULT_DIV = TICK_DEFAULT_DIV
) (
  input  logic clk10,
  input  logic reset,
  input  logic i_load,
  input  logic [CNT_W-1:0] i_div,
  input  mode_t i_mode,
  input  logic i_en,
  input  logic i_resync,
  output logic o_tick,
  output logic o_busy
);
  logic [CNT_W-1:0] r_cnt, r_div;
  mode_t r_mode;
  logic r_tick, r_busy;
  logic w_active;
  assign w_active = i_en && (r_mode == MODE_PERIODIC || r_busy);
  assign o_tick = r_tick;
  assign o_busy = r_busy;
  always_ff @(posedge clk10)
    if (!reset) begin
      r_div <= CNT_W'(DEFAULT_DIV);
      r_mode <= MODE_PERIODIC;
      r_cnt <= '0;
      r_tick <= 1'b0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_div <= (i_div == '0) ? CNT_W'(1) : i_div;
      r_mode <= i_mode;
      r_cnt <= '0;
      r_tick <= 1'b0;
      r_busy <= (i_mode == MODE_ONESHOT);
    end else if (i_resync) begin
      r_cnt <= '0;
      r_tick <= 1'b0;
      r_busy <= (r_mode == MODE_ONESHOT);
    end else if (!w_active) begin
      r_tick <= 1'b0;
    end else if (r_cnt == r_div - CNT_W'(1)) begin
      r_cnt <= '0;
      r_tick <= 1'b1;
      if (r_mode == MODE_ONESHOT) r_busy <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_tick <= 1'b0;
    end
endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: multi-channel clock-enable generator; owns the load handshake and channel decode
module tick_gen_multi import tick_gen_pkg::*; #(
  parameter int CHANNELS = 4,
  parameter int CNT_W = TICK_CNT_W,
  parameter int DEFAULT_DIV = TICK_DEFAULT_DIV
) (
  input  logic clk10,
  input  logic reset,
  tick_gen_if.slave bus,
  input  logic [CHANNELS-1:0] chan_en,
  input  logic resync,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] busy
);
  localparam int CH_W = chan_w(CHANNELS);
  logic r_ready;
  logic w_accept;
  assign w_accept = bus.load_valid && r_ready;
  assign bus.load_ready = r_ready;
  // one dead cycle after every accepted load caps the load rate at one per two cycles
  always_ff @(posedge clk10)
    if (!reset) r_ready <= 1'b1;
    else r_ready <= !w_accept;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic w_hit;
    assign w_hit = w_accept && (bus.load_chan == CH_W'(i));
    tick_gen_chan #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .clk10(clk10),
      .reset(reset),
      .i_load(w_hit),
      .i_div(bus.load_div),
      .i_mode(bus.load_mode),
      .i_en(chan_en[i]),
      .i_resync(resync),
      .o_tick(tick[i]),
      .o_busy(busy[i])
    );
  end
endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed scenarios plus randomized traffic against an elapsed-cycle reference model
module tb_tick_gen_multi;
  import tick_gen_pkg::*;
  localparam int CH = 2;
  localparam int W = 8;
  localparam int DEF = 10;
  logic clk10 = 1'b0;
  logic reset = 1'b0;
  logic resync = 1'b0;
  logic [CH-1:0] chan_en = '0;
  logic [CH-1:0] tick, busy;
  tick_gen_if #(.CHANNELS(CH), .CNT_W(W)) bus();
  tick_gen_multi #(.CHANNELS(CH), .CNT_W(W), .DEFAULT_DIV(DEF)) dut (
    .clk10(clk10),
    .reset(reset),
    .bus(bus),
    .chan_en(chan_en),
    .resync(resync),
    .tick(tick),
    .busy(busy)
  );
  always #5 clk10 = ~clk10;
  int checks = 0;
  int failures = 0;
  // model: count active cycles since the last restart; a tick is due whenever that count is a multiple of div
  int m_div[CH];
  int m_elapsed[CH];
  logic m_mode[CH];
  logic [CH-1:0] m_tick = '0;
  logic [CH-1:0] m_busy = '0;
  logic m_ready = 1'b1;
  task automatic step();
    logic acc;
    @(posedge clk10);
    acc = bus.load_valid && m_ready;
    m_ready = !reset ? 1'b1 : !acc;
    for (int i = 0; i < CH; i++) begin
      if (!reset) begin
        m_div[i] = DEF; m_mode[i] = 1'b0; m_elapsed[i] = 0; m_tick[i] = 1'b0; m_busy[i] = 1'b0;
      end else if (acc && int'(bus.load_chan) == i) begin
        m_div[i] = (int'(bus.load_div) == 0) ? 1 : int'(bus.load_div);
        m_mode[i] = bus.load_mode; m_elapsed[i] = 0; m_tick[i] = 1'b0; m_busy[i] = bus.load_mode;
      end else if (resync) begin
        m_elapsed[i] = 0; m_tick[i] = 1'b0; m_busy[i] = m_mode[i];
      end else if (!chan_en[i] || (m_mode[i] && !m_busy[i])) begin
        m_tick[i] = 1'b0;
      end else begin
        m_elapsed[i]++;
        m_tick[i] = (m_elapsed[i] % m_div[i]) == 0;
        if (m_tick[i] && m_mode[i]) m_busy[i] = 1'b0;
      end
    end
    #1;
  endtask
  task automatic do_load(input int ch, input int d, input int md);
    bus.load_valid = 1'b1;
    bus.load_chan = 1'(ch);
    bus.load_div = W'(d);
    bus.load_mode = mode_t'(md[0]);
    step();
    bus.load_valid = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    chan_en = '1;
    repeat (3) step();
    checks += 3;
    if (tick !== 2'b00) begin failures++; $display("FAIL reset_tick got=%b exp=00", tick); end
    if (busy !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", busy); end
    if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.load_ready); end
    reset = 1'b1;
  endtask
  task automatic test_default_period();
    for (int n = 1; n <= 31; n++) begin
      logic [CH-1:0] e;
      step();
      e = (n % 10 == 0) ? 2'b11 : 2'b00;
      checks += 3;
      if (tick !== e) begin failures++; $display("FAIL default_tick n=%0d got=%b exp=%b", n, tick, e); end
      if (busy !== 2'b00) begin failures++; $display("FAIL default_busy n=%0d got=%b exp=00", n, busy); end
      if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL default_ready n=%0d got=%b exp=1", n, bus.load_ready); end
    end
  endtask
  task automatic test_periodic_load();
    do_load(1, 3, 0);
    checks += 2;
    if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL load_ready_drop got=%b exp=0", bus.load_ready); end
    if (tick[1] !== 1'b0) begin failures++; $display("FAIL load_tick1_clear got=%b exp=0", tick[1]); end
    for (int n = 1; n <= 9; n++) begin
      step();
      checks += 3;
      if (tick[1] !== (n % 3 == 0)) begin failures++; $display("FAIL div3_tick1 n=%0d got=%b exp=%b", n, tick[1], n % 3 == 0); end
      if (tick[0] !== m_tick[0]) begin failures++; $display("FAIL div3_tick0 n=%0d got=%b exp=%b", n, tick[0], m_tick[0]); end
      if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL load_ready_back n=%0d got=%b exp=1", n, bus.load_ready); end
    end
  endtask
  task automatic test_oneshot();
    do_load(0, 5, 1);
    checks++;
    if (busy[0] !== 1'b1) begin failures++; $display("FAIL oneshot_armed got=%b exp=1", busy[0]); end
    for (int n = 1; n <= 10; n++) begin
      step();
      checks += 2;
      if (tick[0] !== (n == 5)) begin failures++; $display("FAIL oneshot_tick n=%0d got=%b exp=%b", n, tick[0], n == 5); end
      if (busy[0] !== (n < 5)) begin failures++; $display("FAIL oneshot_busy n=%0d got=%b exp=%b", n, busy[0], n < 5); end
    end
    resync = 1'b1;
    step();
    resync = 1'b0;
    checks++;
    if (busy[0] !== 1'b1) begin failures++; $display("FAIL oneshot_rearm got=%b exp=1", busy[0]); end
    for (int n = 1; n <= 8; n++) begin
      step();
      checks++;
      if (tick[0] !== (n == 5)) begin failures++; $display("FAIL rearm_tick n=%0d got=%b exp=%b", n, tick[0], n == 5); end
    end
  endtask
  task automatic test_pause();
    do_load(0, 10, 0);
    for (int n = 1; n <= 25; n++) begin
      chan_en[0] = (n < 7 || n > 10);
      step();
      checks++;
      if (tick[0] !== (n == 14 || n == 24)) begin failures++; $display("FAIL pause_tick n=%0d got=%b exp=%b", n, tick[0], n == 14 || n == 24); end
    end
    chan_en[0] = 1'b1;
  endtask
  task automatic test_resync_tc();
    do_load(0, 10, 0);
    for (int n = 1; n <= 22; n++) begin
      resync = (n == 10);
      step();
      checks++;
      if (tick[0] !== (n == 20)) begin failures++; $display("FAIL resync_tc_tick n=%0d got=%b exp=%b", n, tick[0], n == 20); end
    end
    resync = 1'b0;
    do_load(0, 0, 0);
    for (int n = 1; n <= 5; n++) begin
      step();
      checks++;
      if (tick[0] !== 1'b1) begin failures++; $display("FAIL div0_tick n=%0d got=%b exp=1", n, tick[0]); end
    end
  endtask
  task automatic test_reset_mid();
    do_load(1, 3, 0);
    repeat (4) step();
    reset = 1'b0;
    step();
    checks += 3;
    if (tick !== 2'b00) begin failures++; $display("FAIL midreset_tick got=%b exp=00", tick); end
    if (busy !== 2'b00) begin failures++; $display("FAIL midreset_busy got=%b exp=00", busy); end
    if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", bus.load_ready); end
    reset = 1'b1;
    for (int n = 1; n <= 11; n++) begin
      step();
      checks++;
      if (tick !== ((n == 10) ? 2'b11 : 2'b00)) begin failures++; $display("FAIL midreset_div n=%0d got=%b exp=%b", n, tick, (n == 10) ? 2'b11 : 2'b00); end
    end
  endtask
  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) != 0);
      bus.load_valid = ($urandom_range(0, 3) == 0);
      bus.load_chan = 1'($urandom_range(0, 1));
      bus.load_div = W'($urandom_range(0, 12));
      bus.load_mode = mode_t'($urandom_range(0, 1));
      chan_en[0] = ($urandom_range(0, 7) != 0);
      chan_en[1] = ($urandom_range(0, 7) != 0);
      resync = ($urandom_range(0, 31) == 0);
      step();
      checks += 3;
      if (tick !== m_tick) begin failures++; $display("FAIL rand_tick n=%0d got=%b exp=%b", n, tick, m_tick); end
      if (busy !== m_busy) begin failures++; $display("FAIL rand_busy n=%0d got=%b exp=%b", n, busy, m_busy); end
      if (bus.load_ready !== m_ready) begin failures++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, bus.load_ready, m_ready); end
    end
  endtask
  initial begin
    bus.load_valid = 1'b0;
    bus.load_chan = '0;
    bus.load_div = '0;
    bus.load_mode = MODE_PERIODIC;
    #1;
    test_reset();
    test_default_period();
    test_periodic_load();
    test_oneshot();
    test_pause();
    test_resync_tc();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tick_gen_multi.md
# tick_gen_multi

Multi-channel programmable clock-enable generator for the DCF receiver datapath, clocked from the 10 MHz system clock `clk10`. Each channel divides `clk10` by a runtime-loadable divisor and emits one-cycle `tick` enables, in periodic or one-shot mode. A global `resync` restarts all channels so the second/bit-sampling timebases can be phase-aligned to the DCF second mark. Consumers use `tick[i]` as a clock enable; no derived clocks are produced.

## Interface
Parameters:
- `CHANNELS`, default 4: number of independent divider channels (1..16).
- `CNT_W`, default 26: counter and divisor width.
- `DEFAULT_DIV`, default 10000000: reset divisor for every channel (1 s at 10 MHz). Must satisfy 1 ≤ DEFAULT_DIV < 2^CNT_W.

Ports:
- `clk10`, in, 1: system clock, 10 MHz.
- `reset`, in, 1: synchronous, active-low.
- `load_valid`, in, 1: divisor/mode load request.
- `load_ready`, out, 1: load accepted at an edge where `load_valid` && `load_ready`.
- `load_chan`, in, $clog2(CHANNELS) (min 1): target channel. Out-of-range indices are accepted and ignored.
- `load_div`, in, CNT_W: new divisor. 0 is treated as 1.
- `load_mode`, in, 1: 0 = periodic, 1 = one-shot.
- `chan_en`, in, CHANNELS: per-channel run enable. Low = pause.
- `resync`, in, 1: global restart of all counters.
- `tick`, out, CHANNELS: registered one-cycle enable pulses.
- `busy`, out, CHANNELS: one-shot channel armed and not yet fired.

## Operation
- Reset (`reset`=0 at an edge) puts every channel in this state: divisor=DEFAULT_DIV, mode=periodic, counter=0, `tick`=0, `busy`=0, `load_ready`=1. Reset overrides all other inputs, including mid-count and mid-load.
- Per channel, at each edge, in priority order:
  1. Load hit (accepted, `load_chan`=i): divisor←max(`load_div`,1), mode←`load_mode`, counter←0, `tick`←0, `busy`←`load_mode`.
  2. `resync`: counter←0, `tick`←0. One-shot channels re-arm (`busy`←1).
  3. Channel inactive (`chan_en`[i]=0, or one-shot with `busy`=0): counter holds, `tick`←0.
  4. counter==divisor−1: counter←0, `tick`←1. In one-shot mode also `busy`←0.
  5. Otherwise: counter←counter+1, `tick`←0.
- A load and `resync` in the same cycle: the load applies to its channel; `resync` applies to all other channels.
- `resync` coinciding with terminal count suppresses that tick.
- A pause freezes the counter. Resuming continues from the frozen value, so no phase is lost.
- Divisor 1: `tick` is high on every active cycle.
- Counter compare is unsigned CNT_W-bit. The counter never exceeds divisor−1 and therefore never wraps through 2^CNT_W.
- `load_ready` drops to 0 for exactly one cycle after each accepted load, then returns to 1. The maximum load rate is one load per 2 cycles.

## Timing
- `tick` is registered and has no combinational path from any input.
- After a load, resync, or reset release at edge k, with the channel enabled throughout, `tick` is first high during the cycle following edge k+div. It then repeats every div cycles (periodic mode) or stops (one-shot mode).
- While `chan_en` is low for P cycles, the next tick is delayed by exactly P cycles.
- `busy` changes on the same edge as the corresponding load, resync, or final tick.

## Structure
- Package `tick_gen_pkg`:
  - `mode_t` enum {MODE_PERIODIC, MODE_ONESHOT}.
  - Default constants `TICK_CNT_W`=26 and `TICK_DEFAULT_DIV`=10000000.
  - Named divisors for DCF use: `DIV_1S`=10000000, `DIV_100MS`=1000000, `DIV_10MS`=100000.
- Sub-module `tick_gen_chan`: one channel's counter, divisor register, mode and busy flag, implementing the priority list above. It is instantiated CHANNELS times in a generate loop.
- The top level holds the load handshake (`load_ready` register) and channel decode.

## Test plan
Bench parameters: CHANNELS=2, CNT_W=8, DEFAULT_DIV=10.
1. Release reset, both `chan_en`=1 → `tick[0]` and `tick[1]` high on cycles 10, 20, 30 after release; `busy`=0; `load_ready`=1.
2. Load chan 1, div=3, periodic, at edge k → `tick[1]` at k+3, k+6, …; `load_ready`=0 for cycle k+1 only; `tick[0]` unaffected.
3. Load chan 0, div=5, one-shot → `busy[0]`=1, a single `tick[0]` at k+5, `busy[0]`=0 afterwards with no further ticks. Then pulse `resync` → re-armed, and `tick[0]` fires 5 cycles later.
4. Hold `chan_en[0]`=0 for 4 cycles at counter=6 (div 10) → next `tick[0]` occurs 4 cycles later than unpaused.
5. Assert `resync` on a terminal-count cycle → no tick that cycle; the next tick comes 10 cycles later. Also load div=0 → tick every cycle.
6. Assert `reset`=0 mid-count after load div=3 → all outputs return to reset values, divisor restored to 10.
